// File: rtl/pwm_deadtime.sv
// pwm_deadtime: turns the three single-ended PWM commands into complementary
// high-side / low-side gate drives with a programmable dead time per leg.
// Adds enable/coast control and a sticky fault shutdown ahead of the gate drivers.
// Each command is registered once. Each phase then runs its own small FSM and
// dead-time counter. The gate outputs come straight from flops.
// Optional feature: define DT_SWALLOW_CNT_EN to add the swallow_cnt output.
// swallow_cnt counts aborted dead-time intervals and saturates at all-ones.

module pwm_deadtime #(
  parameter int DT_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                en,
  input  logic [DT_WIDTH-1:0] dead_cycles,
  input  logic                pwmA_in,
  input  logic                pwmB_in,
  input  logic                pwmC_in,
  input  logic                fault_in,
  input  logic                fault_clr,
  output logic                pwmA_hi_out,
  output logic                pwmA_lo_out,
  output logic                pwmB_hi_out,
  output logic                pwmB_lo_out,
  output logic                pwmC_hi_out,
  output logic                pwmC_lo_out,
  output logic                fault_out
`ifdef DT_SWALLOW_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] swallow_cnt
`endif
);

  localparam int NPH = 3;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_LO_ON,
    ST_DT_TO_HI,
    ST_HI_ON,
    ST_DT_TO_LO
  } phase_state_t;

  logic [NPH-1:0]      pwm_in;
  logic [NPH-1:0]      cmd_q;
  logic [NPH-1:0]      hi_q;
  logic [NPH-1:0]      lo_q;
  logic                fault_q;
  logic                force_off;
  phase_state_t        state_q [NPH];
  phase_state_t        state_d [NPH];
  logic [DT_WIDTH-1:0] cnt_q   [NPH];
  logic [DT_WIDTH-1:0] cnt_d   [NPH];
`ifdef DT_SWALLOW_CNT_EN
  logic [NPH-1:0]      abort;
`endif

  assign pwm_in = {pwmC_in, pwmB_in, pwmA_in};

  // A new fault, a latched fault or coast forces every leg to OFF.
  // OFF needs no dead time because both gates are already being released.
  assign force_off = fault_in | fault_q | ~en;

  // Per-phase next state and dead-time counter.
  always_comb begin
    for (int p = 0; p < NPH; p++) begin
      // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
`ifdef DT_SWALLOW_CNT_EN
      abort[p]   = 1'b0;
`endif
      if (force_off) begin
        state_d[p] = ST_OFF;
      end else begin
        case (state_q[p])
          // Leaving OFF always goes low side first to precharge the bootstrap.
          ST_OFF: state_d[p] = ST_LO_ON;
          ST_LO_ON: begin
            if (cmd_q[p]) begin
              state_d[p] = ST_DT_TO_HI;
              cnt_d[p]   = dead_cycles;
            end
          end
          ST_DT_TO_HI: begin
            // A command that returns before the gap ends swallows the pulse.
            if (!cmd_q[p]) begin
              state_d[p] = ST_LO_ON;
`ifdef DT_SWALLOW_CNT_EN
              abort[p]   = 1'b1;
`endif
            end else if (cnt_q[p] == '0) begin
              state_d[p] = ST_HI_ON;
            end else begin
              cnt_d[p] = cnt_q[p] - DT_WIDTH'(1);
            end
          end
          ST_HI_ON: begin
            if (!cmd_q[p]) begin
              state_d[p] = ST_DT_TO_LO;
              cnt_d[p]   = dead_cycles;
            end
          end
          ST_DT_TO_LO: begin
            if (cmd_q[p]) begin
              state_d[p] = ST_HI_ON;
`ifdef DT_SWALLOW_CNT_EN
              abort[p]   = 1'b1;
`endif
            end else if (cnt_q[p] == '0) begin
              state_d[p] = ST_LO_ON;
            end else begin
              cnt_d[p] = cnt_q[p] - DT_WIDTH'(1);
            end
          end
          default: state_d[p] = ST_OFF;
        endcase
      end
    end
  end

  // Command, fault, state, counter and gate registers. Reset wins at the edge where it is sampled.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      cmd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      fault_q <= 1'b0;
      for (int p = 0; p < NPH; p++) begin
        // NOTE: these per-phase arrays are a few flops, not a RAM, so they are reset like any other register.
        state_q[p] <= ST_OFF;
        cnt_q[p]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let all state update together at the edge, whatever the statement order.
      cmd_q <= pwm_in;
      if (fault_in) begin
        fault_q <= 1'b1;
      end else if (fault_clr) begin
        fault_q <= 1'b0;
      end
      for (int p = 0; p < NPH; p++) begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
        // Gates are decoded from the next state and then registered, so they never glitch.
        hi_q[p]    <= (state_d[p] == ST_HI_ON);
        lo_q[p]    <= (state_d[p] == ST_LO_ON);
      end
    end
  end

`ifdef DT_SWALLOW_CNT_EN
  logic [CNT_WIDTH-1:0] swallow_q;
  logic [1:0]           n_abort;
  logic [CNT_WIDTH:0]   swallow_sum;

  // Add the number of phases that aborted at this edge. The extra bit of swallow_sum flags overflow.
  always_comb begin
    n_abort     = 2'(abort[0]) + 2'(abort[1]) + 2'(abort[2]);
    swallow_sum = {1'b0, swallow_q} + (CNT_WIDTH + 1)'(n_abort);
  end

  // Saturating swallowed-pulse counter. An accepted fault clear also zeroes it.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      swallow_q <= '0;
    end else if (fault_clr && !fault_in) begin
      swallow_q <= '0;
    end else if (swallow_sum[CNT_WIDTH]) begin
      swallow_q <= '1;
    end else begin
      swallow_q <= swallow_sum[CNT_WIDTH-1:0];
    end
  end

  assign swallow_cnt = swallow_q;
`endif

  assign pwmA_hi_out = hi_q[0];
  assign pwmA_lo_out = lo_q[0];
  assign pwmB_hi_out = hi_q[1];
  assign pwmB_lo_out = lo_q[1];
  assign pwmC_hi_out = hi_q[2];
  assign pwmC_lo_out = lo_q[2];
  assign fault_out   = fault_q;

endmodule
